// File: rtl/pc_stack_sequencer.sv
// pc_stack_sequencer: program counter, return/data stack, interrupt enable and
// HALT state of the 16-bit MCU. Executes one 4-bit control code per ctrl_valid
// pulse. The RUN/HALTED state register drives the halted output directly, so
// the FSM state is always observable.
//
// Handshake: ctrl_valid is a one-cycle qualifier with no back-pressure (there
// is no ready). Every cycle with ctrl_valid=1 carries exactly one instruction,
// which is consumed on that rising edge. In HALTED, or when an interrupt is
// taken in the same cycle, the instruction is dropped.
module pc_stack_sequencer #(
  parameter int          DEPTH    = 16,
  parameter int          SP_W     = 5,
  parameter logic [11:0] RESET_PC = 12'h000,
  parameter logic [11:0] ISR_VEC  = 12'hFF0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ctrl_valid,
  input  logic [3:0]      ctrl_code,
  input  logic [11:0]     pc_branch,
  input  logic            carry,
  input  logic            zero,
  input  logic [15:0]     a_to_stack,
  input  logic            irq,
  output logic [11:0]     pc,
  output logic [15:0]     stack_to_a,
  output logic            pop_valid,
  output logic            ie,
  output logic            halted,
  output logic            irq_ack,
  output logic [SP_W-1:0] sp,
  output logic            stk_ovf,
  output logic            stk_unf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);

  localparam logic [3:0] C_JMP    = 4'b0000;
  localparam logic [3:0] C_JSR    = 4'b0001;
  localparam logic [3:0] C_PUSHA  = 4'b0010;
  localparam logic [3:0] C_POPA   = 4'b0011;
  localparam logic [3:0] C_RET    = 4'b0100;
  localparam logic [3:0] C_SKIP_C = 4'b0101;
  localparam logic [3:0] C_SKIP_Z = 4'b0110;
  localparam logic [3:0] C_ION    = 4'b0111;
  localparam logic [3:0] C_IOF    = 4'b1000;
  localparam logic [3:0] C_HALT   = 4'b1001;

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [11:0]       pc_q, pc_d;
  logic              ie_q, ie_d;
  logic              irq_ack_q, irq_ack_d;
  logic              pop_valid_q, popa_d;
  logic [15:0]       stack_to_a_q;
  logic [SP_W-1:0]   sp_q;
  logic              ovf_q, unf_q;
  logic              push_d, pop_d;
  logic [15:0]       push_data_d;
  logic [15:0]       mem [DEPTH];

  logic              full, empty, take_irq;
  logic [AW-1:0]     wr_idx, rd_idx;
  logic [15:0]       rd_data;
  logic [11:0]       pc_inc1, pc_inc2;

  assign full     = (sp_q == SP_FULL);
  assign empty    = (sp_q == '0);
  // sp==DEPTH wraps wr_idx to 0, but a full push never writes, and
  // rd_idx = sp-1 is correct for every non-empty sp.
  assign wr_idx   = sp_q[AW-1:0];
  assign rd_idx   = sp_q[AW-1:0] - AW'(1);
  assign rd_data  = mem[rd_idx];
  assign take_irq = ie_q && irq;
  assign pc_inc1  = pc_q + 12'd1;
  assign pc_inc2  = pc_q + 12'd2;

  // Next-state decode: an interrupt beats any instruction; otherwise execute in RUN.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ie_d        = ie_q;
    irq_ack_d   = 1'b0;
    popa_d      = 1'b0;
    push_d      = 1'b0;
    pop_d       = 1'b0;
    push_data_d = 16'h0000;
    if (take_irq) begin
      // The return address is the current pc, so the dropped instruction reruns.
      push_d      = 1'b1;
      push_data_d = {4'h0, pc_q};
      pc_d        = ISR_VEC;
      ie_d        = 1'b0;
      irq_ack_d   = 1'b1;
      state_d     = RUN;
    end else if (state_q == RUN && ctrl_valid) begin
      unique case (ctrl_code)
        C_JMP:    pc_d = pc_branch;
        C_JSR: begin
          push_d      = 1'b1;
          push_data_d = {4'h0, pc_inc1};
          pc_d        = pc_branch;
        end
        C_PUSHA: begin
          push_d      = 1'b1;
          push_data_d = a_to_stack;
          pc_d        = pc_inc1;
        end
        C_POPA: begin
          pop_d  = 1'b1;
          popa_d = 1'b1;
          pc_d   = pc_inc1;
        end
        C_RET: begin
          pop_d = 1'b1;
          pc_d  = empty ? pc_inc1 : rd_data[11:0];
        end
        C_SKIP_C: pc_d = carry ? pc_inc2 : pc_inc1;
        C_SKIP_Z: pc_d = zero  ? pc_inc2 : pc_inc1;
        C_ION: begin
          ie_d = 1'b1;
          pc_d = pc_inc1;
        end
        C_IOF: begin
          ie_d = 1'b0;
          pc_d = pc_inc1;
        end
        C_HALT: begin
          pc_d    = pc_inc1;
          state_d = HALTED;
        end
        default:  pc_d = pc_inc1;
      endcase
    end
  end

  // Control registers, stack pointer and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      ie_q         <= 1'b0;
      irq_ack_q    <= 1'b0;
      pop_valid_q  <= 1'b0;
      stack_to_a_q <= 16'h0000;
      sp_q         <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ie_q        <= ie_d;
      irq_ack_q   <= irq_ack_d;
      pop_valid_q <= popa_d;
      if (push_d) begin
        if (full) ovf_q <= 1'b1;
        else      sp_q  <= sp_q + SP_W'(1);
      end else if (pop_d) begin
        if (empty) unf_q <= 1'b1;
        else       sp_q  <= sp_q - SP_W'(1);
      end
      if (popa_d && !empty) stack_to_a_q <= rd_data;
    end
  end

  // Stack storage: contents are not reset, only sp is.
  always_ff @(posedge clk) begin
    if (push_d && !full) mem[wr_idx] <= push_data_d;
  end

  assign pc         = pc_q;
  assign stack_to_a = stack_to_a_q;
  assign pop_valid  = pop_valid_q;
  assign ie         = ie_q;
  assign halted     = (state_q == HALTED);
  assign irq_ack    = irq_ack_q;
  assign sp         = sp_q;
  assign stk_ovf    = ovf_q;
  assign stk_unf    = unf_q;

endmodule

// File: tb/tb_pc_stack_sequencer.sv
// Bench for pc_stack_sequencer: directed scenarios followed by random
// instruction streams, all checked against a queue-based reference model.
module tb_pc_stack_sequencer;

  localparam int DEPTH = 16;
  localparam int SP_W  = 5;
  localparam logic [11:0] ISR = 12'hFF0;

  localparam logic [3:0] INC = 4'b1111, JMP = 4'b0000, JSR = 4'b0001, PUSHA = 4'b0010,
                         POPA = 4'b0011, RET = 4'b0100, SKIP_C = 4'b0101, SKIP_Z = 4'b0110,
                         ION = 4'b0111, IOF = 4'b1000, HALT = 4'b1001;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            ctrl_valid = 1'b0;
  logic [3:0]      ctrl_code = 4'h0;
  logic [11:0]     pc_branch = '0;
  logic            carry = 1'b0, zero = 1'b0, irq = 1'b0;
  logic [15:0]     a_to_stack = '0;
  logic [11:0]     pc;
  logic [15:0]     stack_to_a;
  logic            pop_valid, ie, halted, irq_ack, stk_ovf, stk_unf;
  logic [SP_W-1:0] sp;

  pc_stack_sequencer #(.DEPTH(DEPTH), .SP_W(SP_W), .RESET_PC(12'h000), .ISR_VEC(ISR)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_valid(ctrl_valid), .ctrl_code(ctrl_code),
    .pc_branch(pc_branch), .carry(carry), .zero(zero), .a_to_stack(a_to_stack), .irq(irq),
    .pc(pc), .stack_to_a(stack_to_a), .pop_valid(pop_valid), .ie(ie), .halted(halted),
    .irq_ack(irq_ack), .sp(sp), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  // reference model state
  logic [11:0] m_pc;
  logic [15:0] m_stk[$];
  logic [15:0] m_sta;
  logic        m_ie, m_halt, m_pv, m_ack, m_ovf, m_unf;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, "_pc"},  32'(pc),         32'(m_pc));
    check_eq({tag, "_sp"},  32'(sp),         m_stk.size());
    check_eq({tag, "_sta"}, 32'(stack_to_a), 32'(m_sta));
    check_eq({tag, "_pv"},  32'(pop_valid),  32'(m_pv));
    check_eq({tag, "_ie"},  32'(ie),         32'(m_ie));
    check_eq({tag, "_hlt"}, 32'(halted),     32'(m_halt));
    check_eq({tag, "_ack"}, 32'(irq_ack),    32'(m_ack));
    check_eq({tag, "_ovf"}, 32'(stk_ovf),    32'(m_ovf));
    check_eq({tag, "_unf"}, 32'(stk_unf),    32'(m_unf));
  endtask

  task automatic model_reset();
    m_pc = 12'h000; m_stk.delete(); m_sta = '0;
    m_ie = 0; m_halt = 0; m_pv = 0; m_ack = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic m_push(input logic [15:0] d);
    if (m_stk.size() == DEPTH) m_ovf = 1;
    else m_stk.push_back(d);
  endtask

  // One instruction slot as the architecture defines it.
  task automatic model_step(input logic v, input logic [3:0] code, input logic [11:0] br,
                            input logic c, input logic z, input logic [15:0] a, input logic i);
    logic [15:0] d;
    m_pv = 0; m_ack = 0;
    if (m_ie && i) begin
      m_push({4'h0, m_pc});
      m_pc = ISR; m_ie = 0; m_ack = 1; m_halt = 0;
    end else if (!m_halt && v) begin
      case (code)
        JMP:    m_pc = br;
        JSR:    begin m_push({4'h0, m_pc + 12'd1}); m_pc = br; end
        PUSHA:  begin m_push(a); m_pc = m_pc + 1; end
        POPA:   begin
                  if (m_stk.size() == 0) m_unf = 1; else m_sta = m_stk.pop_back();
                  m_pv = 1; m_pc = m_pc + 1;
                end
        RET:    begin
                  if (m_stk.size() == 0) begin m_unf = 1; m_pc = m_pc + 1; end
                  else begin d = m_stk.pop_back(); m_pc = d[11:0]; end
                end
        SKIP_C: m_pc = m_pc + (c ? 12'd2 : 12'd1);
        SKIP_Z: m_pc = m_pc + (z ? 12'd2 : 12'd1);
        ION:    begin m_ie = 1; m_pc = m_pc + 1; end
        IOF:    begin m_ie = 0; m_pc = m_pc + 1; end
        HALT:   begin m_halt = 1; m_pc = m_pc + 1; end
        default: m_pc = m_pc + 1;
      endcase
    end
  endtask

  // driver: apply one slot, advance one edge, compare everything
  task automatic step(input string tag, input logic v, input logic [3:0] code,
                      input logic [11:0] br = 12'h0, input logic c = 0, input logic z = 0,
                      input logic [15:0] a = 16'h0, input logic i = 0);
    ctrl_valid = v; ctrl_code = code; pc_branch = br; carry = c; zero = z;
    a_to_stack = a; irq = i;
    model_step(v, code, br, c, z, a, i);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  // asynchronous reset pulse between clock edges; outputs checked before any edge
  task automatic do_reset(input string tag);
    ctrl_valid = 0; irq = 0;
    #2 rst_n = 0;
    #1 model_reset();
    compare_all(tag);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    logic [15:0] pushed[$];
    model_reset();
    #7;
    compare_all("rst0");
    @(negedge clk);
    rst_n = 1;

    // 1) INC chain, JMP, wrap
    for (int k = 0; k < 5; k++) step("t1_inc", 1, INC);
    check_eq("t1_pc5", 32'(pc), 32'h005);
    step("t1_jmp", 1, JMP, 12'h123);
    check_eq("t1_pc123", 32'(pc), 32'h123);
    step("t1_jmpf", 1, JMP, 12'hFFF);
    step("t1_wrap", 1, INC);
    check_eq("t1_pc0", 32'(pc), 32'h000);

    // 2) subroutine and data stack
    step("t2_jmp", 1, JMP, 12'h010);
    step("t2_jsr", 1, JSR, 12'h200);
    step("t2_push", 1, PUSHA, 12'h0, 0, 0, 16'hABCD);
    check_eq("t2_sp2", 32'(sp), 32'd2);
    step("t2_popa", 1, POPA);
    check_eq("t2_sta", 32'(stack_to_a), 32'hABCD);
    check_eq("t2_pv", 32'(pop_valid), 32'd1);
    step("t2_ret", 1, RET);
    check_eq("t2_pc", 32'(pc), 32'h011);

    // 3) skips, including wrap at FFE
    step("t3_jmp", 1, JMP, 12'h020);
    step("t3_skc", 1, SKIP_C, 12'h0, 1, 0);
    step("t3_skz0", 1, SKIP_Z, 12'h0, 0, 0);
    check_eq("t3_pc23", 32'(pc), 32'h023);
    step("t3_jmpe", 1, JMP, 12'hFFE);
    step("t3_skz1", 1, SKIP_Z, 12'h0, 0, 1);
    check_eq("t3_pc0", 32'(pc), 32'h000);

    // 4) overflow then underflow
    for (int k = 0; k <= DEPTH; k++) begin
      logic [15:0] d;
      d = 16'($urandom_range(0, 16'hFFFF));
      pushed.push_back(d);
      step("t4_push", 1, PUSHA, 12'h0, 0, 0, d);
    end
    check_eq("t4_ovf", 32'(stk_ovf), 32'd1);
    for (int k = 0; k <= DEPTH; k++) step("t4_pop", 1, POPA);
    check_eq("t4_unf", 32'(stk_unf), 32'd1);
    check_eq("t4_first", 32'(stack_to_a), 32'(pushed[0]));

    // 5) interrupt discards concurrent JMP
    step("t5_jmp", 1, JMP, 12'h030);
    step("t5_ion", 1, ION, 12'h0, 0, 0, 16'h0, 1);   // irq in ION cycle not taken
    step("t5_irq", 1, JMP, 12'h300, 0, 0, 16'h0, 1);
    check_eq("t5_pc", 32'(pc), 32'hFF0);
    check_eq("t5_ack", 32'(irq_ack), 32'd1);
    step("t5_ret", 1, RET);
    check_eq("t5_pcret", 32'(pc), 32'h031);

    // 6) HALT, wake by interrupt, RET, mid-run reset
    step("t6_jmp", 1, JMP, 12'h03F);
    step("t6_ion", 1, ION);
    step("t6_halt", 1, HALT);
    for (int k = 0; k < 4; k++)
      step("t6_frz", 1, 4'($urandom_range(0, 15)), 12'h555, 1, 1);
    check_eq("t6_pc041", 32'(pc), 32'h041);
    step("t6_wake", 0, INC, 12'h0, 0, 0, 16'h0, 1);
    step("t6_ret", 1, RET);
    check_eq("t6_pcret", 32'(pc), 32'h041);
    step("t6_jsr", 1, JSR, 12'h777);
    do_reset("t6_rst");

    // random streams
    for (int n = 0; n < 2000; n++) begin
      logic [3:0] code;
      int r;
      r = $urandom_range(0, 99);
      code = (r < 2) ? HALT : 4'($urandom_range(0, 15));
      if (r >= 2 && code == HALT) code = INC;
      step("rnd", ($urandom_range(0, 9) != 0), code, 12'($urandom_range(0, 4095)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
           ($urandom_range(0, 7) == 0));
      if ((m_halt && !m_ie) || (n % 500 == 499)) do_reset("rnd_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
